// File: rtl/round_robin_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// round_robin_bus_arbiter_if
// Bus-request interface between the snoopy-bus caches and the arbiter.
//   requests     : per-cache request lines (held for the whole transaction)
//   grants       : one-hot (or zero) ownership vector
//   busy         : high while any grant is high
//   ownerIndex   : binary index of the current owner, 0 when idle
//   timeoutPulse : one-cycle pulse when an owner is forcibly revoked
// Modports: master = requesting side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface round_robin_bus_arbiter_if #(
    parameter int NUMBER_OF_DEVICES = 4
);
    localparam int IDX_W = (NUMBER_OF_DEVICES > 1) ? $clog2(NUMBER_OF_DEVICES) : 1;

    logic [NUMBER_OF_DEVICES-1:0] requests;
    logic [NUMBER_OF_DEVICES-1:0] grants;
    logic                         busy;
    logic [IDX_W-1:0]             ownerIndex;
    logic                         timeoutPulse;

    modport master (
        output requests,
        input  grants, busy, ownerIndex, timeoutPulse
    );

    modport slave (
        input  requests,
        output grants, busy, ownerIndex, timeoutPulse
    );
endinterface

// File: rtl/round_robin_bus_arbiter.sv
// ---------------------------------------------------------------------------
// round_robin_bus_arbiter
// Round-robin arbiter for a snoopy bus shared by NUMBER_OF_DEVICES caches.
// An owner keeps the bus as long as it holds its request; when it drops,
// the next requester in round-robin order is granted on the same edge.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : round_robin_bus_arbiter_if.slave (requests in; grants, busy,
//           ownerIndex, timeoutPulse out -- all registered)
//
// Optional feature: define ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN to compile in
// a hold counter that revokes an owner after TIMEOUT_CYCLES grant cycles.
// Without it, timeoutPulse is tied low and grants are held indefinitely.
// ---------------------------------------------------------------------------
module round_robin_bus_arbiter #(
    parameter int NUMBER_OF_DEVICES = 4,
    parameter int TIMEOUT_CYCLES    = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    round_robin_bus_arbiter_if.slave bus
);
    localparam int N     = NUMBER_OF_DEVICES;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {IDLE, GRANTED, RELEASE} state_t;
`else
    typedef enum logic {IDLE, GRANTED} state_t;
`endif

    state_t           state_q, state_d;
    logic [N-1:0]     grants_q, grants_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;
    logic             pulse_q, pulse_d;
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Round-robin search: candidates ptr+1 .. ptr+N (ptr itself last).
    // Walking from the far end lets the nearest requester overwrite the
    // result, so no early exit is needed.
    logic             found;
    logic [IDX_W-1:0] next_idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        cand     = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % N);
            if (bus.requests[cand]) begin
                found    = 1'b1;
                next_idx = cand;
            end
        end
    end

    logic take_new;

    always_comb begin
        state_d  = state_q;
        grants_d = grants_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        pulse_d  = 1'b0;
        take_new = 1'b0;
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: take_new = 1'b1;
            GRANTED: begin
                if (bus.requests[owner_q]) begin
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Revoke; ptr stays on the revoked owner so it is
                        // searched last when arbitration resumes.
                        state_d  = RELEASE;
                        grants_d = '0;
                        owner_d  = '0;
                        pulse_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end else begin
                    // Owner dropped: hand over on this same edge.
                    take_new = 1'b1;
                end
            end
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
            // The RELEASE cycle carries no grant; its exit edge arbitrates
            // as IDLE would, so only one dead cycle follows a revocation.
            RELEASE: take_new = 1'b1;
`endif
            default: begin
                state_d  = IDLE;
                grants_d = '0;
                owner_d  = '0;
            end
        endcase

        if (take_new) begin
            if (found) begin
                state_d  = GRANTED;
                grants_d = N'(1) << next_idx;
                owner_d  = next_idx;
                ptr_d    = next_idx;
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end else begin
                state_d  = IDLE;
                grants_d = '0;
                owner_d  = '0;
            end
        end

        busy_d = |grants_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            grants_q <= '0;
            owner_q  <= '0;
            ptr_q    <= IDX_W'(N - 1);   // device 0 wins the first arbitration
            busy_q   <= 1'b0;
            pulse_q  <= 1'b0;
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grants_q <= grants_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            pulse_q  <= pulse_d;
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.grants     = grants_q;
    assign bus.busy       = busy_q;
    assign bus.ownerIndex = owner_q;
    assign bus.timeoutPulse = pulse_q;

endmodule

// File: tb/tb_round_robin_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_round_robin_bus_arbiter
// Directed bench for round_robin_bus_arbiter (4 devices, TIMEOUT_CYCLES = 8).
// Each step drives reset/requests, pushes the expected post-edge outputs to
// a scoreboard queue, and pops/compares them one time unit after the edge.
// ---------------------------------------------------------------------------
module tb_round_robin_bus_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] g;
        logic         p;
        string        tag;
    } exp_t;

    logic clock;
    logic reset;
    exp_t sb[$];
    int   n_total;
    int   n_pass;

    round_robin_bus_arbiter_if #(.NUMBER_OF_DEVICES(N)) bus ();

    round_robin_bus_arbiter #(
        .NUMBER_OF_DEVICES(N),
        .TIMEOUT_CYCLES   (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [1:0] enc(input logic [N-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic step(input logic rst_v, input logic [N-1:0] req,
                        input logic [N-1:0] exp_g, input logic exp_p,
                        input string tag);
        exp_t e;
        exp_t o;
        reset        = rst_v;
        bus.requests = req;
        e.g = exp_g; e.p = exp_p; e.tag = tag;
        sb.push_back(e);
        @(posedge clock);
        #1;
        o = sb.pop_front();
        n_total++;
        assert (bus.grants === o.g) n_pass++;
        else $error("FAIL %s grants got %b want %b", o.tag, bus.grants, o.g);
        n_total++;
        assert (bus.busy === (|o.g)) n_pass++;
        else $error("FAIL %s busy got %b want %b", o.tag, bus.busy, |o.g);
        n_total++;
        assert (bus.ownerIndex === enc(o.g)) n_pass++;
        else $error("FAIL %s ownerIndex got %0d want %0d", o.tag, bus.ownerIndex, enc(o.g));
        n_total++;
        assert (bus.timeoutPulse === o.p) n_pass++;
        else $error("FAIL %s timeoutPulse got %b want %b", o.tag, bus.timeoutPulse, o.p);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset        = 1'b0;
        bus.requests = '0;
        @(negedge clock);

        // Reset state
        step(0, 4'b0000, 4'b0000, 0, "reset0");
        step(0, 4'b1111, 4'b0000, 0, "reset_req");

        // Idle with no requests
        for (int i = 0; i < 5; i++) step(1, 4'b0000, 4'b0000, 0, "idle");

        // All request, each owner holds 3 cycles, back-to-back handover
        step(1, 4'b1111, 4'b0001, 0, "rr_g0");
        step(1, 4'b1111, 4'b0001, 0, "rr_g0");
        step(1, 4'b1111, 4'b0001, 0, "rr_g0");
        step(1, 4'b1110, 4'b0010, 0, "rr_g1");
        step(1, 4'b1111, 4'b0010, 0, "rr_g1");
        step(1, 4'b1111, 4'b0010, 0, "rr_g1");
        step(1, 4'b1101, 4'b0100, 0, "rr_g2");
        step(1, 4'b1111, 4'b0100, 0, "rr_g2");
        step(1, 4'b1111, 4'b0100, 0, "rr_g2");
        step(1, 4'b1011, 4'b1000, 0, "rr_g3");
        step(1, 4'b1111, 4'b1000, 0, "rr_g3");
        step(1, 4'b1111, 4'b1000, 0, "rr_g3");
        step(1, 4'b0111, 4'b0001, 0, "rr_wrap0");
        step(1, 4'b0000, 4'b0000, 0, "rr_idle");

        // Owner 2, no preemption, wrap-around to device 0
        step(1, 4'b0100, 4'b0100, 0, "own2");
        step(1, 4'b0111, 4'b0100, 0, "own2_hold");
        step(1, 4'b0011, 4'b0001, 0, "wrap_to0");
        step(1, 4'b0000, 4'b0000, 0, "wrap_idle");

        // Drop in the same cycle as granted
        step(1, 4'b0010, 4'b0010, 0, "drop_g1");
        step(1, 4'b0000, 4'b0000, 0, "drop_lost");

        // Search order from pointer 1
        step(1, 4'b0101, 4'b0100, 0, "order_2");
        step(1, 4'b0001, 4'b0001, 0, "order_0");
        step(1, 4'b0000, 4'b0000, 0, "order_idle");

        // Mid-transaction reset
        step(1, 4'b0010, 4'b0010, 0, "mid_g1");
        step(0, 4'b0010, 4'b0000, 0, "mid_reset");
        step(1, 4'b0010, 4'b0010, 0, "mid_regrant1");
        step(1, 4'b0000, 4'b0000, 0, "mid_idle");
        step(1, 4'b0001, 4'b0001, 0, "ptr_g0");
        step(0, 4'b0011, 4'b0000, 0, "ptr_reset");
        step(1, 4'b0011, 4'b0001, 0, "ptr_restored");
        step(1, 4'b0000, 4'b0000, 0, "ptr_idle");

        // Long hold by device 3 with device 0 also waiting
        step(1, 4'b1001, 4'b1000, 0, "hold_g3");
`ifdef ROUND_ROBIN_BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) step(1, 4'b1001, 4'b1000, 0, "to_hold");
        step(1, 4'b1001, 4'b0000, 1, "to_revoke");
        step(1, 4'b1001, 4'b0001, 0, "to_next0");
        step(1, 4'b1001, 4'b0001, 0, "to_hold0");
`else
        for (int i = 0; i < 200; i++) step(1, 4'b1001, 4'b1000, 0, "nto_hold");
`endif
        step(1, 4'b0000, 4'b0000, 0, "end_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
